burst_fetch: RTL and testbench
==============================

# burst_fetch

Parametrised burst memory reader for the audio path. On `start` it issues `length` consecutive word reads from `base_addr` and delivers the returned words in order on a valid/ready stream. Optionally it replays the window continuously until `stop`. It sits between the sample memory and the audio output logic, and it replaces one-word-per-start fetching with pipelined, back-pressured bursts.

## Interface
- `DATA_W`, 16, memory word / stream width
- `ADDR_W`, 16, memory address width
- `LEN_W`, 8, width of burst length field
- `RD_LATENCY`, 1, cycles from `mem_read` to valid `mem_data` (>= 1)
- `FIFO_DEPTH`, 4, output buffer entries (power of two, >= RD_LATENCY+1)

- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low; clears all state
- `start` in 1: begin burst; honoured only in IDLE
- `stop` in 1: end issuing (abort burst / end loop); honoured only in ISSUE
- `loop` in 1: sampled with `start`; 1 = replay window until `stop`
- `base_addr` in ADDR_W: first address; sampled with `start`
- `length` in LEN_W: words per window; sampled with `start`
- `mem_read` out 1: read strobe, one word per cycle high
- `mem_addr` out ADDR_W: read address; 0 when `mem_read`=0
- `mem_data` in DATA_W: read data, valid RD_LATENCY cycles after its strobe
- `data_out` out DATA_W: head of output FIFO
- `data_valid` out 1: FIFO non-empty
- `data_ready` in 1: consumer accepts when `data_valid`&`data_ready`
- `busy` out 1: high in ISSUE and DRAIN
- `done` out 1: one-cycle pulse at end of operation

## Operation
- States:
  - IDLE: on `start`, latch `base_addr`/`length`/`loop`, clear index `idx`, and go to ISSUE. If `length`=0, go to DONE instead.
  - ISSUE: perform reads. On `stop`, or after the last read of a non-loop burst, go to DRAIN.
  - DRAIN: no reads are issued. Go to DONE when outstanding=0 and the FIFO is empty.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Issue rule: in ISSUE, `mem_read`=1 iff (outstanding + fifo_count) < FIFO_DEPTH and `stop`=0.
  - The credit check does not count a pop in the same cycle.
- Address: `mem_addr` = `base_addr` + `idx`, modulo 2^ADDR_W, so the address wraps past all-ones to 0.
- Index: `idx` increments on each read.
  - At `idx`=`length`-1, non-loop mode issues its final read.
  - In loop mode, `idx` returns to 0 and reading continues.
- Outstanding tracking: a RD_LATENCY-deep strobe shift register.
  - When a tap emerges, `mem_data` is written into the FIFO that cycle.
  - Credit gating guarantees the FIFO never overflows.
- Ordering: the stream carries words in issue order, with no drops or duplicates.
- `stop` on the final read cycle: the read is suppressed and the block goes to DRAIN.
- `start` outside IDLE is ignored. `stop` outside ISSUE is ignored.
- `start` and `stop` together in IDLE: `start` wins.
- `data_out` is held stable while `data_valid`=1 and `data_ready`=0.
- Reset mid-operation:
  - All state is cleared immediately: FIFO emptied, outstanding cleared, state set to IDLE.
  - Memory data that returns after reset is ignored.

## Timing
- Reset values: `mem_read`=0, `mem_addr`=0, `data_out`=0, `data_valid`=0, `busy`=0, `done`=0; internal state IDLE.
- `start` sampled high at the edge ending cycle 0 means ISSUE in cycle 1. The first `mem_read` goes high in cycle 1 with `mem_addr`=`base_addr`.
- A read strobed in cycle t has its data captured at the end of cycle t+RD_LATENCY.
  - That word can be on `data_valid`/`data_out` from cycle t+RD_LATENCY+1 at the earliest.
  - With an empty FIFO it appears exactly then.
- With `data_ready` held high, sustained throughput is 1 word/cycle if FIFO_DEPTH >= RD_LATENCY+2. Otherwise the block stalls on credit.
- `mem_read`/`mem_addr` are combinational from state and registers. `data_out`/`data_valid` are driven from FIFO registers.
- `length`=0: `done` is high in cycle 1; there are no reads and `busy` stays 0.
- `done` is high for exactly one cycle per operation. `start` is accepted again in the cycle after `done`.

## Test plan
- Single burst: base=0x0010, length=4, RD_LATENCY=1, ready=1.
  - Reads in cycles 1-4 at 0x0010..0x0013.
  - Data valid in cycles 3-6 in order.
  - `done` is high in cycle 7.
- Backpressure: length=8, ready=0 for 10 cycles, then 1.
  - Exactly FIFO_DEPTH reads are issued, then `mem_read`=0.
  - `data_out` stays stable.
  - All 8 words arrive in order; no overflow.
- Wrap: base=0xFFFE, length=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Loop then stop: loop=1, base=0x0100, length=3.
  - Addresses cycle 0x100, 0x101, 0x102, 0x100, ….
  - `stop` pulse: no further reads.
  - In-flight words are delivered, then a single `done` pulse.
- Corner cases:
  - length=0 → `done` in cycle 1, no `mem_read`.
  - `start` while busy is ignored.
  - `start`+`stop` in IDLE starts the burst.
- Reset mid-burst: assert `reset`=0 during ISSUE with words in the FIFO.
  - All outputs go to reset values immediately.
  - Late `mem_data` is not delivered.
  - A new `start` works normally.

Source files
------------

// File: rtl/burst_fetch_if.sv
// Memory read port plus output sample stream of the burst fetcher, in one bundle.
// master: the fetcher side (drives mem_read/mem_addr, data_out/data_valid).
// slave : memory + consumer side (drives mem_data, data_ready).
interface burst_fetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output mem_read, mem_addr, data_out, data_valid,
    input  mem_data, data_ready
  );

  modport slave (
    input  mem_read, mem_addr, data_out, data_valid,
    output mem_data, data_ready
  );
endinterface

// File: rtl/burst_fetch.sv
// Burst memory reader: on start issues `length` word reads from base_addr (optionally looping
// until stop) and streams the returned words in order. Word read in cycle t is visible at t+RD_LATENCY+1.
// Backpressure: reads are credit-gated on (in-flight + buffered) < FIFO_DEPTH, so data_ready low stalls issue.
// Ports: clock/reset (async active-low); start/stop/loop/base_addr/length control; busy/done status;
// bus (master): mem_read/mem_addr/mem_data memory port, data_out/data_valid/data_ready output stream.
module burst_fetch #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 8,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  burst_fetch_if.master     bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_r;
  logic [LEN_W-1:0]  len_r;
  logic              loop_r;
  logic [LEN_W-1:0]  idx;

  // One bit per read in flight; the top tap marks the cycle its data is on mem_data.
  logic [RD_LATENCY-1:0] rd_pipe;
  logic [CNT_W-1:0]      outstanding;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_vld, push, pop;

  logic credit_ok, rd_fire, last_idx;

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      outstanding = outstanding + CNT_W'(rd_pipe[i]);
    end
  end

  // A pop in the same cycle is deliberately not credited back; keeps the gate off the ready path.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_cnt}) < SUM_W'(FIFO_DEPTH);
  assign rd_fire   = (state == S_ISSUE) && !stop && credit_ok;
  assign last_idx  = (idx == len_r - LEN_W'(1));
  assign fifo_vld  = (fifo_cnt != '0);
  assign push      = rd_pipe[RD_LATENCY-1];
  assign pop       = fifo_vld && bus.data_ready;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (length == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (stop || (rd_fire && !loop_r && last_idx)) state_nxt = S_DRAIN;
      // Leave DRAIN in the cycle the last word is popped so done follows immediately.
      S_DRAIN: if (rd_pipe == '0 && (fifo_cnt == '0 || (fifo_cnt == CNT_W'(1) && pop)))
                 state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.mem_read = rd_fire;
    bus.mem_addr = rd_fire ? (base_r + ADDR_W'(idx)) : '0;
    busy         = (state == S_ISSUE) || (state == S_DRAIN);
    done         = (state == S_DONE);
  end

  // Burst registers and read index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base_r <= '0;
      len_r  <= '0;
      loop_r <= 1'b0;
      idx    <= '0;
    end else if (state == S_IDLE && start) begin
      base_r <= base_addr;
      len_r  <= length;
      loop_r <= loop;
      idx    <= '0;
    end else if (rd_fire) begin
      idx <= last_idx ? '0 : idx + LEN_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= rd_fire;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // Output FIFO bookkeeping; clearing rd_pipe on reset drops any data still returning.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_data;
  end

  always_comb begin
    bus.data_valid = fifo_vld;
    bus.data_out   = fifo_vld ? fifo_mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_burst_fetch.sv
// Directed bench for burst_fetch (default parameters, RD_LATENCY=1, FIFO_DEPTH=4).
// Memory model returns (addr ^ 16'h5A00) one cycle after each strobe.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_burst_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        loop  = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  length = '0;
  logic        busy, done;

  burst_fetch_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  burst_fetch dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    bus.mem_data <= bus.mem_read ? (bus.mem_addr ^ 16'h5A00) : 16'hDEAD;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_done = 0;
  bit          timed_out = 1'b0;
  logic [15:0] addr_q[$];
  logic [15:0] got_q[$];

  task automatic clear_log();
    addr_q.delete();
    got_q.delete();
    n_done = 0;
    timed_out = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] b, input logic [7:0] len, input logic lp, input logic stp);
    @(negedge clock);
    base_addr = b; length = len; loop = lp; start = 1'b1; stop = stp;
    @(posedge clock); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  // Logs issued addresses and accepted words each cycle until done or the cycle budget runs out.
  task automatic collect(input int max_cycles);
    timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clock); #1;
      if (bus.mem_read) addr_q.push_back(bus.mem_addr);
      if (bus.data_valid && bus.data_ready) got_q.push_back(bus.data_out);
      if (done) begin n_done++; timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.data_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_mem_read got %b want 0", bus.mem_read); end
    n_cmp++; if (bus.mem_addr !== 16'h0) begin n_fail++; $display("FAIL rst_mem_addr got %h want 0000", bus.mem_addr); end
    n_cmp++; if (bus.data_out !== 16'h0) begin n_fail++; $display("FAIL rst_data_out got %h want 0000", bus.data_out); end
    n_cmp++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_data_valid got %b want 0", bus.data_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_single_burst();
    logic        e_rd, e_vld, e_done, e_busy;
    logic [15:0] e_addr, e_dat;
    bus.data_ready = 1'b1;
    pulse_start(16'h0010, 8'd4, 1'b0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock); #1;
      e_rd   = (c >= 1 && c <= 4);
      e_addr = e_rd ? 16'h0010 + 16'(c - 1) : 16'h0000;
      e_vld  = (c >= 3 && c <= 6);
      e_dat  = 16'h5A10 + 16'(c - 3);
      e_done = (c == 7);
      e_busy = (c <= 6);
      n_cmp++; if (bus.mem_read !== e_rd) begin n_fail++; $display("FAIL single_rd c%0d got %b want %b", c, bus.mem_read, e_rd); end
      n_cmp++; if (bus.mem_addr !== e_addr) begin n_fail++; $display("FAIL single_addr c%0d got %h want %h", c, bus.mem_addr, e_addr); end
      n_cmp++; if (bus.data_valid !== e_vld) begin n_fail++; $display("FAIL single_vld c%0d got %b want %b", c, bus.data_valid, e_vld); end
      if (e_vld) begin
        n_cmp++; if (bus.data_out !== e_dat) begin n_fail++; $display("FAIL single_dat c%0d got %h want %h", c, bus.data_out, e_dat); end
      end
      n_cmp++; if (done !== e_done) begin n_fail++; $display("FAIL single_done c%0d got %b want %b", c, done, e_done); end
      n_cmp++; if (busy !== e_busy) begin n_fail++; $display("FAIL single_busy c%0d got %b want %b", c, busy, e_busy); end
    end
  endtask

  task automatic test_backpressure();
    int n_rd = 0;
    clear_log();
    bus.data_ready = 1'b0;
    pulse_start(16'h0020, 8'd8, 1'b0, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock); #1;
      if (bus.mem_read) begin n_rd++; addr_q.push_back(bus.mem_addr); end
      if (c >= 3) begin
        n_cmp++; if (bus.data_valid !== 1'b1 || bus.data_out !== 16'h5A20) begin
          n_fail++; $display("FAIL bp_hold c%0d got vld=%b dat=%h want vld=1 dat=5a20", c, bus.data_valid, bus.data_out);
        end
      end
    end
    n_cmp++; if (n_rd !== 4) begin n_fail++; $display("FAIL bp_credit_reads got %0d want 4", n_rd); end
    @(negedge clock);
    bus.data_ready = 1'b1;
    #1;
    if (bus.mem_read) addr_q.push_back(bus.mem_addr);
    if (bus.data_valid) got_q.push_back(bus.data_out);
    collect(40);
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got %b want 0", timed_out); end
    n_cmp++; if (addr_q.size() !== 8) begin n_fail++; $display("FAIL bp_nreads got %0d want 8", addr_q.size()); end
    n_cmp++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL bp_nwords got %0d want 8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      n_cmp++; if (got_q[i] !== 16'h5A20 + 16'(i)) begin n_fail++; $display("FAIL bp_word%0d got %h want %h", i, got_q[i], 16'h5A20 + 16'(i)); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] ea [4];
    logic [15:0] ew [4];
    ea = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    ew = '{16'hA5FE, 16'hA5FF, 16'h5A00, 16'h5A01};
    clear_log();
    bus.data_ready = 1'b1;
    pulse_start(16'hFFFE, 8'd4, 1'b0, 1'b0);
    collect(30);
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL wrap_timeout got %b want 0", timed_out); end
    n_cmp++; if (addr_q.size() !== 4 || got_q.size() !== 4) begin
      n_fail++; $display("FAIL wrap_count got reads=%0d words=%0d want 4/4", addr_q.size(), got_q.size());
    end
    for (int i = 0; i < 4 && i < addr_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (addr_q[i] !== ea[i]) begin n_fail++; $display("FAIL wrap_addr%0d got %h want %h", i, addr_q[i], ea[i]); end
      n_cmp++; if (got_q[i] !== ew[i]) begin n_fail++; $display("FAIL wrap_word%0d got %h want %h", i, got_q[i], ew[i]); end
    end
  endtask

  task automatic test_loop_stop();
    logic [15:0] ea [7];
    logic [15:0] ew [7];
    ea = '{16'h0100, 16'h0101, 16'h0102, 16'h0100, 16'h0101, 16'h0102, 16'h0100};
    ew = '{16'h5B00, 16'h5B01, 16'h5B02, 16'h5B00, 16'h5B01, 16'h5B02, 16'h5B00};
    clear_log();
    bus.data_ready = 1'b1;
    pulse_start(16'h0100, 8'd3, 1'b1, 1'b0);
    loop = 1'b0;
    collect(7);
    @(negedge clock);
    stop = 1'b1;
    #1;
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL loop_stop_rd got %b want 0", bus.mem_read); end
    if (bus.data_valid) got_q.push_back(bus.data_out);
    @(posedge clock); #1;
    stop = 1'b0;
    collect(30);
    n_cmp++; if (timed_out !== 1'b0 || n_done !== 1) begin
      n_fail++; $display("FAIL loop_done got timeout=%b dones=%0d want 0/1", timed_out, n_done);
    end
    n_cmp++; if (addr_q.size() !== 7 || got_q.size() !== 7) begin
      n_fail++; $display("FAIL loop_count got reads=%0d words=%0d want 7/7", addr_q.size(), got_q.size());
    end
    for (int i = 0; i < 7 && i < addr_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (addr_q[i] !== ea[i]) begin n_fail++; $display("FAIL loop_addr%0d got %h want %h", i, addr_q[i], ea[i]); end
      n_cmp++; if (got_q[i] !== ew[i]) begin n_fail++; $display("FAIL loop_word%0d got %h want %h", i, got_q[i], ew[i]); end
    end
    @(negedge clock); #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL loop_after got busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_corners();
    // length 0: immediate done, no read, never busy
    pulse_start(16'h0200, 8'd0, 1'b0, 1'b0);
    @(negedge clock); #1;
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL len0_done got %b want 1", done); end
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL len0_rd got %b want 0", bus.mem_read); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy got %b want 0", busy); end
    @(negedge clock); #1;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL len0_done_pulse got %b want 0", done); end

    // start while busy is ignored
    clear_log();
    pulse_start(16'h0030, 8'd4, 1'b0, 1'b0);
    @(negedge clock);
    base_addr = 16'h0040; length = 8'd2; start = 1'b1;
    #1;
    if (bus.mem_read) addr_q.push_back(bus.mem_addr);
    @(posedge clock); #1;
    start = 1'b0;
    collect(30);
    n_cmp++; if (addr_q.size() !== 4 || n_done !== 1) begin
      n_fail++; $display("FAIL busy_start_count got reads=%0d dones=%0d want 4/1", addr_q.size(), n_done);
    end
    if (addr_q.size() == 4) begin
      n_cmp++; if (addr_q[3] !== 16'h0033) begin n_fail++; $display("FAIL busy_start_addr got %h want 0033", addr_q[3]); end
    end
    if (got_q.size() == 4) begin
      n_cmp++; if (got_q[3] !== 16'h5A33) begin n_fail++; $display("FAIL busy_start_word got %h want 5a33", got_q[3]); end
    end

    // start and stop together in IDLE: start wins
    clear_log();
    pulse_start(16'h0050, 8'd2, 1'b0, 1'b1);
    collect(30);
    n_cmp++; if (addr_q.size() !== 2 || got_q.size() !== 2 || n_done !== 1) begin
      n_fail++; $display("FAIL startstop_count got reads=%0d words=%0d dones=%0d want 2/2/1", addr_q.size(), got_q.size(), n_done);
    end
    if (got_q.size() == 2) begin
      n_cmp++; if (got_q[0] !== 16'h5A50 || got_q[1] !== 16'h5A51) begin
        n_fail++; $display("FAIL startstop_words got %h %h want 5a50 5a51", got_q[0], got_q[1]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bus.data_ready = 1'b0;
    pulse_start(16'h0060, 8'd8, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock); #1;
    end
    n_cmp++; if (bus.data_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre got vld=%b busy=%b want 1/1", bus.data_valid, busy);
    end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.data_valid !== 1'b0 || bus.data_out !== 16'h0 || busy !== 1'b0 || done !== 1'b0 ||
                 bus.mem_read !== 1'b0 || bus.mem_addr !== 16'h0) begin
      n_fail++; $display("FAIL midrst_outputs got vld=%b dat=%h busy=%b done=%b rd=%b addr=%h want all 0",
                         bus.data_valid, bus.data_out, busy, done, bus.mem_read, bus.mem_addr);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock); #1;
      n_cmp++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_late_data c%0d got vld=%b want 0", c, bus.data_valid); end
    end
    clear_log();
    bus.data_ready = 1'b1;
    pulse_start(16'h0070, 8'd2, 1'b0, 1'b0);
    collect(30);
    n_cmp++; if (got_q.size() !== 2 || n_done !== 1) begin
      n_fail++; $display("FAIL midrst_restart got words=%0d dones=%0d want 2/1", got_q.size(), n_done);
    end
    if (got_q.size() == 2) begin
      n_cmp++; if (got_q[0] !== 16'h5A70 || got_q[1] !== 16'h5A71) begin
        n_fail++; $display("FAIL midrst_words got %h %h want 5a70 5a71", got_q[0], got_q[1]);
      end
    end
  endtask

  initial begin
    bus.data_ready = 1'b1;
    test_reset();
    test_single_burst();
    test_backpressure();
    test_wrap();
    test_loop_stop();
    test_corners();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
